// File: rtl/hls_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hls_seq_pkg                                                          |
// | Shared state encoding and constants for the HLS run sequencer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hls_seq_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_LOAD   = 3'd1,
      SEQ_START  = 3'd2,
      SEQ_RUN    = 3'd3,
      SEQ_RESULT = 3'd4
   } seq_state_e;

   localparam logic [1:0] SEQ_ST_OK      = 2'b00;
   localparam logic [1:0] SEQ_ST_TIMEOUT = 2'b01;
   localparam logic [6:0] SEQ_BYTE_SIZE  = 7'd8;

endpackage
`default_nettype wire

// File: rtl/hls_slave_byte_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hls_slave_byte_writer                                                |
// | Byte-at-a-time preload writer for slave RAM channel 0.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hls_slave_byte_writer
   import hls_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              init_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] nbytes_i,
   input  logic              active_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   input  logic              ack_i,
   output logic              ld_ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [7:0]        data_o,
   output logic [6:0]        size_o,
   output logic              last_ack_o
);

   logic              pending_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rem_q;
   logic [7:0]        data_q;
   logic              take;
   logic              acked;

   assign ld_ready_o = active_i & ~pending_q;
   assign take       = ld_valid_i & ld_ready_o;
   // Acks arriving with no write outstanding are dropped here.
   assign acked      = pending_q & ack_i;
   assign last_ack_o = acked & (rem_q == ADDR_W'(1));

   assign we_o   = pending_q;
   assign addr_o = pending_q ? addr_q : '0;
   assign data_o = pending_q ? data_q : '0;
   assign size_o = pending_q ? SEQ_BYTE_SIZE : 7'd0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
         rem_q     <= '0;
         data_q    <= '0;
      end else begin
         if (init_i) begin
            pending_q <= 1'b0;
            addr_q    <= base_i;
            rem_q     <= nbytes_i;
         end else if (take) begin
            pending_q <= 1'b1;
            data_q    <= ld_data_i;
         end else if (acked) begin
            pending_q <= 1'b0;
            addr_q    <= addr_q + ADDR_W'(1);
            rem_q     <= rem_q - ADDR_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hls_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hls_run_sequencer                                                    |
// | Sequences one preload/start/measure run of a Bambu HLS accelerator.  |
// | Optional watchdog: define HLS_SEQ_WATCHDOG_EN.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hls_run_sequencer
   import hls_seq_pkg::*;
#(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 200000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run_valid,
   output logic                  run_ready,
   input  logic [ADDR_W-1:0]     run_nbytes,
   input  logic [ADDR_W-1:0]     run_base,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [7:0]            ld_data,
   output logic                  start_port,
   input  logic                  done_port,
   output logic [1:0]            S_oe_ram,
   output logic [1:0]            S_we_ram,
   output logic [2*ADDR_W-1:0]   S_addr_ram,
   output logic [2*DATA_W-1:0]   S_Wdata_ram,
   output logic [13:0]           S_data_ram_size,
   input  logic [1:0]            Sout_DataRdy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [1:0]            res_status,
   output logic [CNT_W-1:0]      res_cycles
);

   seq_state_e        state_q;
   logic              run_ready_q;
   logic              start_q;
   logic              res_valid_q;
   logic [1:0]        res_status_q;
   logic [CNT_W-1:0]  res_cycles_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;
   logic              accept;
   logic              wr_we;
   logic              wr_last_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [6:0]        wr_size;
   logic              unused_ok;

   assign accept    = run_valid & run_ready_q;
   assign unused_ok = Sout_DataRdy[1];

`ifdef HLS_SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CYCLES);
   logic limit_hit;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign limit_hit = (cnt_inc == C_MAX);
`else
   // Without a watchdog the count pins at all-ones instead of wrapping.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`endif

   hls_slave_byte_writer #(
      .ADDR_W (ADDR_W)
   ) u_writer (
      .clock      (clock),
      .reset      (reset),
      .init_i     (accept),
      .base_i     (run_base),
      .nbytes_i   (run_nbytes),
      .active_i   (state_q == SEQ_LOAD),
      .ld_valid_i (ld_valid),
      .ld_data_i  (ld_data),
      .ack_i      (Sout_DataRdy[0]),
      .ld_ready_o (ld_ready),
      .we_o       (wr_we),
      .addr_o     (wr_addr),
      .data_o     (wr_data),
      .size_o     (wr_size),
      .last_ack_o (wr_last_ack)
   );

   assign run_ready       = run_ready_q;
   assign start_port      = start_q;
   assign res_valid       = res_valid_q;
   assign res_status      = res_status_q;
   assign res_cycles      = res_cycles_q;
   assign S_oe_ram        = 2'b00;
   assign S_we_ram        = {1'b0, wr_we};
   assign S_addr_ram      = {{ADDR_W{1'b0}}, wr_addr};
   assign S_Wdata_ram     = {{(2*DATA_W-8){1'b0}}, wr_data};
   assign S_data_ram_size = {7'd0, wr_size};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= SEQ_IDLE;
         run_ready_q  <= 1'b1;
         start_q      <= 1'b0;
         res_valid_q  <= 1'b0;
         res_status_q <= SEQ_ST_OK;
         res_cycles_q <= '0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (accept) begin
                  run_ready_q <= 1'b0;
                  if (run_nbytes == '0) begin
                     state_q <= SEQ_START;
                     start_q <= 1'b1;
                  end else begin
                     state_q <= SEQ_LOAD;
                  end
               end
            end
            SEQ_LOAD: begin
               if (wr_last_ack) begin
                  state_q <= SEQ_START;
                  start_q <= 1'b1;
               end
            end
            SEQ_START: begin
               // The start cycle itself is count 1.
               start_q <= 1'b0;
               cnt_q   <= CNT_W'(1);
               state_q <= SEQ_RUN;
            end
            SEQ_RUN: begin
               cnt_q <= cnt_inc;
               if (done_port) begin
                  res_cycles_q <= cnt_inc;
                  res_status_q <= SEQ_ST_OK;
                  res_valid_q  <= 1'b1;
                  state_q      <= SEQ_RESULT;
               end
`ifdef HLS_SEQ_WATCHDOG_EN
               else if (limit_hit) begin
                  res_cycles_q <= C_MAX;
                  res_status_q <= SEQ_ST_TIMEOUT;
                  res_valid_q  <= 1'b1;
                  state_q      <= SEQ_RESULT;
               end
`endif
            end
            SEQ_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  run_ready_q <= 1'b1;
                  state_q     <= SEQ_IDLE;
               end
            end
            default: begin
               state_q     <= SEQ_IDLE;
               run_ready_q <= 1'b1;
               start_q     <= 1'b0;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hls_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hls_run_sequencer                                                 |
// | Directed bench for hls_run_sequencer; HLS_SEQ_WATCHDOG_EN adds the   |
// | timeout scenario.                                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hls_run_sequencer;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 32;
   localparam int MAXC   = 20;

   logic                clock = 1'b0;
   logic                reset;
   logic                run_valid;
   logic                run_ready;
   logic [ADDR_W-1:0]   run_nbytes;
   logic [ADDR_W-1:0]   run_base;
   logic                ld_valid;
   logic                ld_ready;
   logic [7:0]          ld_data;
   logic                start_port;
   logic                done_port;
   logic [1:0]          S_oe_ram;
   logic [1:0]          S_we_ram;
   logic [2*ADDR_W-1:0] S_addr_ram;
   logic [2*DATA_W-1:0] S_Wdata_ram;
   logic [13:0]         S_data_ram_size;
   logic [1:0]          Sout_DataRdy;
   logic                res_valid;
   logic                res_ready;
   logic [1:0]          res_status;
   logic [CNT_W-1:0]    res_cycles;

   int n_pass  = 0;
   int n_total = 0;

   hls_run_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .run_valid       (run_valid),
      .run_ready       (run_ready),
      .run_nbytes      (run_nbytes),
      .run_base        (run_base),
      .ld_valid        (ld_valid),
      .ld_ready        (ld_ready),
      .ld_data         (ld_data),
      .start_port      (start_port),
      .done_port       (done_port),
      .S_oe_ram        (S_oe_ram),
      .S_we_ram        (S_we_ram),
      .S_addr_ram      (S_addr_ram),
      .S_Wdata_ram     (S_Wdata_ram),
      .S_data_ram_size (S_data_ram_size),
      .Sout_DataRdy    (Sout_DataRdy),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_status      (res_status),
      .res_cycles      (res_cycles)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic accept_run(input logic [8:0] nb, input logic [8:0] base);
      chk("run_ready_idle", run_ready, 1);
      run_valid  = 1'b1;
      run_nbytes = nb;
      run_base   = base;
      step();
      run_valid = 1'b0;
      chk("run_ready_busy", run_ready, 0);
   endtask

   task automatic load_bytes(input logic [8:0] nb, input logic [8:0] base,
                             input logic [7:0] d0, input int ack_dly);
      for (int i = 0; i < int'(nb); i++) begin
         logic [8:0] a;
         logic [7:0] d;
         a = base + 9'(i);
         d = d0 + 8'(i);
         chk("ld_ready_free", ld_ready, 1);
         chk("we_idle", S_we_ram, 0);
         ld_valid = 1'b1;
         ld_data  = d;
         step();
         ld_valid = 1'b0;
         ld_data  = 8'h00;
         for (int w = 0; w <= ack_dly; w++) begin
            if (w == ack_dly) Sout_DataRdy = 2'b01;
            chk("we_pend", S_we_ram, 2'b01);
            chk("addr", S_addr_ram, {9'd0, a});
            chk("wdata", S_Wdata_ram, {120'd0, d});
            chk("size", S_data_ram_size, 14'd8);
            chk("ld_ready_pend", ld_ready, 0);
            step();
         end
         Sout_DataRdy = 2'b00;
         chk("start_after_ack", start_port, (i == int'(nb) - 1));
      end
   endtask

   // Entered at the start_port cycle; done_after = RUN cycle index of done (0 = never).
   task automatic run_to_result(input int done_after, input bit done_in_start,
                                input int exp_cyc, input logic [1:0] exp_st);
      int k;
      chk("start_pulse", start_port, 1);
      chk("we_quiet", S_we_ram, 0);
      done_port = done_in_start;
      step();
      done_port = 1'b0;
      chk("start_drop", start_port, 0);
      k = 1;
      while (res_valid !== 1'b1 && k < 200) begin
         if (k == done_after) done_port = 1'b1;
         step();
         done_port = 1'b0;
         k++;
      end
      chk("result_latency", k, exp_cyc);
      chk("res_valid", res_valid, 1);
      chk("res_cycles", res_cycles, exp_cyc);
      chk("res_status", res_status, exp_st);
      chk("run_ready_result", run_ready, 0);
   endtask

   task automatic take_result(input int hold, input int exp_cyc, input logic [1:0] exp_st);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("res_hold_valid", res_valid, 1);
         chk("res_hold_cycles", res_cycles, exp_cyc);
         chk("res_hold_status", res_status, exp_st);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
      chk("run_ready_back", run_ready, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_run_ready"}, run_ready, 1);
      chk({tag, "_start"}, start_port, 0);
      chk({tag, "_we"}, S_we_ram, 0);
      chk({tag, "_ld_ready"}, ld_ready, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_status"}, res_status, 0);
      chk({tag, "_res_cycles"}, res_cycles, 0);
      chk({tag, "_size"}, S_data_ram_size, 0);
      chk({tag, "_addr"}, S_addr_ram, 0);
   endtask

   initial begin
      reset        = 1'b1;
      run_valid    = 1'b0;
      run_nbytes   = '0;
      run_base     = '0;
      ld_valid     = 1'b0;
      ld_data      = '0;
      done_port    = 1'b0;
      Sout_DataRdy = 2'b00;
      res_ready    = 1'b0;
      #2;
      check_reset_outputs("por");
      chk("oe_tied", S_oe_ram, 0);
      @(negedge clock);
      reset = 1'b0;

      // Preload smoke: 4 bytes at 0x10, same-cycle ack, done 9 cycles after start.
      accept_run(9'd4, 9'h010);
      load_bytes(9'd4, 9'h010, 8'hA1, 0);
      run_to_result(9, 1'b1, 10, 2'b00);
      take_result(0, 10, 2'b00);

      // Ack stalls with address wrap, stray ack, and a run request held during LOAD.
      accept_run(9'd3, 9'h1FE);
      run_valid    = 1'b1;
      run_nbytes   = 9'd0;
      run_base     = 9'h055;
      Sout_DataRdy = 2'b11;
      step();
      Sout_DataRdy = 2'b00;
      load_bytes(9'd3, 9'h1FE, 8'h30, 3);
      run_valid = 1'b0;
      run_to_result(4, 1'b0, 5, 2'b00);
      take_result(5, 5, 2'b00);

      // Zero-length run, done in the first RUN cycle.
      accept_run(9'd0, 9'h040);
      run_to_result(1, 1'b0, 2, 2'b00);
      take_result(0, 2, 2'b00);

      // Done on the limit cycle.
      accept_run(9'd0, 9'h000);
      run_to_result(MAXC - 1, 1'b0, MAXC, 2'b00);
      take_result(1, MAXC, 2'b00);

`ifdef HLS_SEQ_WATCHDOG_EN
      accept_run(9'd0, 9'h000);
      run_to_result(0, 1'b0, MAXC, 2'b01);
      take_result(2, MAXC, 2'b01);
`endif

      // Reset in LOAD with a write pending.
      accept_run(9'd2, 9'h020);
      ld_valid = 1'b1;
      ld_data  = 8'h77;
      step();
      ld_valid = 1'b0;
      chk("pend_before_reset", S_we_ram, 2'b01);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_load");
      @(negedge clock);
      reset = 1'b0;

      // Reset during the start pulse.
      accept_run(9'd0, 9'h000);
      chk("start_before_reset", start_port, 1);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_start");
      @(negedge clock);
      reset = 1'b0;

      // Reset in RUN.
      accept_run(9'd0, 9'h000);
      step();
      step();
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_run");
      @(negedge clock);
      reset = 1'b0;

      // Fresh run after reset.
      accept_run(9'd1, 9'h030);
      load_bytes(9'd1, 9'h030, 8'h5A, 1);
      run_to_result(2, 1'b0, 3, 2'b00);
      take_result(1, 3, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hls_run_sequencer.md
# hls_run_sequencer

Controller that sequences one run of a Bambu-generated HLS accelerator (`main`-style top with `start_port`/`done_port` and a 2-channel slave RAM port). It accepts a run command, preloads accelerator memory byte-by-byte through slave channel 0, and pulses `start_port`. It then measures the cycles until `done_port` and returns a status/cycle-count result. It replaces the behavioural testbench sequencing with synthesizable RTL for on-board regression.

## Interface
- `ADDR_W`, 9: per-channel slave address width.
- `DATA_W`, 64: per-channel slave data width.
- `CNT_W`, 32: cycle-counter width.
- `MAX_CYCLES`, 200000000: watchdog limit in cycles, must be < 2^CNT_W.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run_valid`  in  1  run request.
- `run_ready`  out  1  sequencer idle; run accepted on `run_valid & run_ready`.
- `run_nbytes`  in  ADDR_W  bytes to preload, sampled at accept.
- `run_base`  in  ADDR_W  preload start address, sampled at accept.
- `ld_valid`  in  1  preload byte available.
- `ld_ready`  out  1  sequencer takes byte.
- `ld_data`  in  8  preload byte.
- `start_port`  out  1  accelerator start pulse.
- `done_port`  in  1  accelerator done.
- `S_oe_ram`  out  2  slave read enables, constant 0.
- `S_we_ram`  out  2  slave write enables, bit 0 only.
- `S_addr_ram`  out  2*ADDR_W  slave addresses, channel 0 in low half.
- `S_Wdata_ram`  out  2*DATA_W  slave write data, byte in bits [7:0].
- `S_data_ram_size`  out  14  access size per channel, 7 bits each; 8 on channel 0 during write, else 0.
- `Sout_DataRdy`  in  2  slave acknowledge, bit 0 used.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_status`  out  2  00 OK, 01 TIMEOUT.
- `res_cycles`  out  CNT_W  measured cycles.

## Operation
- FSM states:
  - IDLE: `run_ready`=1. On accept, go to LOAD, or to START if `run_nbytes`=0.
  - LOAD: `ld_ready`=1 only when no write is pending. A byte taken on `ld_valid & ld_ready` becomes a pending write from the next cycle: `S_we_ram[0]`=1, addr=`run_base`+i (wraps modulo 2^ADDR_W), size=8, all held stable until `Sout_DataRdy[0]`=1. After the ack of byte `run_nbytes`-1, go to START.
  - START: `start_port`=1 for exactly this cycle. Counter loads 1. `done_port` is ignored in this cycle. Go to RUN.
  - RUN: counter increments each cycle.
    - `done_port`=1: latch `res_cycles`=cnt+1 and status OK, go to RESULT.
    - Otherwise, if cnt+1 == MAX_CYCLES: latch `res_cycles`=MAX_CYCLES and status TIMEOUT, go to RESULT.
    - Done and the limit in the same cycle: OK wins.
  - RESULT: `res_valid`=1 with stable status and cycles until `res_ready`. Go to IDLE on the following edge.
- Channel 1 and all read outputs are tied 0.
- `Sout_DataRdy[0]` outside a pending write is ignored. `done_port` outside RUN is ignored.
- `run_valid` while busy: not accepted, no side effect.

## Timing
- Reset values: `run_ready`=1 (IDLE); all other outputs 0, including `start_port`, `S_we_ram`, `ld_ready`, `res_valid`, `res_status`, `res_cycles`.
- Reset mid-run returns to IDLE asynchronously. `start_port` and `S_we_ram` drop immediately, and any pending write is abandoned.
- Accept at edge T: LOAD from T+1, with `ld_ready`=1 in the cycle after T.
- Write throughput: 1 byte per 2 cycles when `Sout_DataRdy` acks in the same cycle as the write request; each extra ack wait adds 1 cycle.
- Last ack at edge A: `start_port` high in cycle A+1.
- Count definition: inclusive from the `start_port` cycle through the `done_port` cycle. `done_port` in the first RUN cycle gives `res_cycles`=2.
- Result handshake at edge R: `run_ready`=1 in cycle R+1.

## Configuration
- `HLS_SEQ_WATCHDOG_EN` defined: MAX_CYCLES timeout as above.
- Undefined:
  - No timeout; RUN waits indefinitely for `done_port`.
  - Counter saturates at 2^CNT_W-1.
  - `res_status` is always 00.
  - The MAX_CYCLES compare logic is absent.

## Structure
- Package `hls_seq_pkg`: the FSM state enum (IDLE, LOAD, START, RUN, RESULT), status constants `SEQ_ST_OK`=2'b00 and `SEQ_ST_TIMEOUT`=2'b01, and the size constant `SEQ_BYTE_SIZE`=7'd8.
- Sub-module `hls_slave_byte_writer`: owns the pending-write register, address generation, and the ack handshake for channel 0.
- The top-level block holds the FSM, the counter, and the result registers.

## Test plan
- Preload smoke: `run_nbytes`=4, `run_base`=0x10, bytes 0xA1..0xA4, ack same cycle → writes to 0x10..0x13 with matching data, one `start_port` pulse, `done_port` 9 cycles after start → `res_cycles`=10, status 00.
- Ack stalls: `Sout_DataRdy` delayed 3 cycles per byte → address, data and size held stable throughout, no byte lost or duplicated, `ld_ready`=0 while a write is pending.
- Zero-length run: `run_nbytes`=0 → no `S_we_ram` activity, `start_port` in the cycle after accept.
- Watchdog (macro on, MAX_CYCLES=20): `done_port` never asserts → status 01, `res_cycles`=20. Done on the limit cycle → status 00, `res_cycles`=20.
- Backpressure and busy: `res_ready`=0 for 5 cycles → result stable; a `run_valid` asserted during LOAD is ignored until IDLE.
- Reset in RUN and in LOAD with a write pending → all outputs at reset values without waiting for a clock edge; a fresh run afterwards completes normally.
